icache_ctrl: RTL and testbench

- Direct-mapped instruction cache between the CPU fetch port (PC in, INSTRUCTION out) and the 1 KiB byte-addressed instruction memory.
- Memory is reached through a block-read handshake (MEM_READ / MEM_BUSYWAIT).
- On a hit, returns the 32-bit instruction combinationally.
- On a miss, stalls the CPU via BUSYWAIT, fetches the 16-byte block, installs it, then serves the hit.

---
 rtl/icache_pkg.sv | 19 +
 rtl/icache_array.sv | 41 ++++
 rtl/icache_ctrl.sv | 90 +++++++++
 tb/tb_icache_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared geometry and FSM state type for the direct-mapped instruction cache.
package icache_pkg;

    localparam int unsigned ADDR_W      = 10;
    localparam int unsigned NUM_BLOCKS  = 8;
    localparam int unsigned BLOCK_BYTES = 16;

    localparam int unsigned OFFSET_W = $clog2(BLOCK_BYTES / 4);
    localparam int unsigned INDEX_W  = $clog2(NUM_BLOCKS);
    localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W - 2;
    localparam int unsigned BLOCK_W  = BLOCK_BYTES * 8;

    typedef enum logic [1:0] {
        StIdle,
        StMemRead,
        StUpdate
    } state_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: one synchronous write port, one combinational read port.
module icache_array
    import icache_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               we_i,
    input  logic [INDEX_W-1:0] waddr_i,
    input  logic [TAG_W-1:0]   wtag_i,
    input  logic [BLOCK_W-1:0] wdata_i,
    input  logic [INDEX_W-1:0] raddr_i,
    output logic               rvalid_o,
    output logic [TAG_W-1:0]   rtag_o,
    output logic [BLOCK_W-1:0] rdata_o
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[waddr_i] <= 1'b1;
        end
    end

    // Tag and data are deliberately not reset; valid gates their use.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[waddr_i]  <= wtag_i;
            data_q[waddr_i] <= wdata_i;
        end
    end

    assign rvalid_o = valid_q[raddr_i];
    assign rtag_o   = tag_q[raddr_i];
    assign rdata_o  = data_q[raddr_i];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache: hit compare, word select and block-refill FSM.
module icache_ctrl
    import icache_pkg::*;
(
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  PC,
    output logic [31:0]  INSTRUCTION,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic [5:0]   MEM_ADDRESS,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);

    state_e               state_q;
    logic [INDEX_W-1:0]   req_index_q;
    logic [TAG_W-1:0]     req_tag_q;

    logic [OFFSET_W-1:0]  pc_offset;
    logic [INDEX_W-1:0]   pc_index;
    logic [TAG_W-1:0]     pc_tag;
    logic                 rd_valid;
    logic [TAG_W-1:0]     rd_tag;
    logic [BLOCK_W-1:0]   rd_data;
    logic                 hit;
    logic                 fill_we;
    logic                 unused_pc;

    assign pc_offset = PC[3:2];
    assign pc_index  = PC[6:4];
    assign pc_tag    = PC[9:7];
    assign unused_pc = ^{PC[31:ADDR_W], PC[1:0]};

    assign hit     = rd_valid && (rd_tag == pc_tag);
    assign fill_we = RESET && (state_q == StMemRead) && !MEM_BUSYWAIT;

    icache_array u_array (
        .clk_i    (CLK),
        .rst_ni   (RESET),
        .we_i     (fill_we),
        .waddr_i  (req_index_q),
        .wtag_i   (req_tag_q),
        .wdata_i  (MEM_READDATA),
        .raddr_i  (pc_index),
        .rvalid_o (rd_valid),
        .rtag_o   (rd_tag),
        .rdata_o  (rd_data)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= StIdle;
            req_index_q <= '0;
            req_tag_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!hit) begin
                        req_index_q <= pc_index;
                        req_tag_q   <= pc_tag;
                        state_q     <= StMemRead;
                    end
                end
                StMemRead: begin
                    if (!MEM_BUSYWAIT) begin
                        state_q <= StUpdate;
                    end
                end
                StUpdate: state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    // Outputs are forced to their quiescent values while RESET is held low.
    always_comb begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b0;
        MEM_ADDRESS = '0;
        INSTRUCTION = '0;
        if (RESET) begin
            BUSYWAIT    = (state_q == StIdle) ? !hit : 1'b1;
            MEM_READ    = (state_q == StMemRead);
            MEM_ADDRESS = {req_tag_q, req_index_q};
            INSTRUCTION = rd_data[{pc_offset, 5'b00000} +: 32];
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl with a latency-programmable block memory model.
module tb_icache_ctrl;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT = 1'b1;

    int tests = 0;
    int fails = 0;
    int mem_lat = 4;
    int busy_cnt = 0;
    int req_cnt = 0;
    logic mr_prev = 1'b0;

    logic [127:0] mem [64];

    int          st;
    logic [31:0] ins;
    logic [5:0]  ad;
    int          r0;
    int          n;

    icache_ctrl dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    assign MEM_READDATA = mem[MEM_ADDRESS];

    // Memory reports busy for mem_lat cycles of each request, then data-valid.
    always @(negedge CLK) begin
        if (MEM_READ) begin
            if (busy_cnt < mem_lat) begin
                MEM_BUSYWAIT = 1'b1;
                busy_cnt++;
            end else begin
                MEM_BUSYWAIT = 1'b0;
            end
        end else begin
            MEM_BUSYWAIT = 1'b1;
            busy_cnt = 0;
        end
    end

    always @(posedge CLK) begin
        mr_prev <= MEM_READ;
        if (MEM_READ && !mr_prev) req_cnt <= req_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives pc, counts stall samples, captures requested block address (3f = none).
    task automatic fetch(input logic [31:0] pc, output int stall, output logic [31:0] instr,
                         output logic [5:0] addr);
        PC = pc;
        #1;
        stall = 0;
        addr = 6'h3f;
        while (BUSYWAIT && stall < 100) begin
            if (MEM_READ) addr = MEM_ADDRESS;
            @(negedge CLK);
            #1;
            stall++;
        end
        instr = INSTRUCTION;
        @(negedge CLK);
    endtask

    initial begin
        for (int b = 0; b < 64; b++) begin
            for (int w = 0; w < 4; w++) begin
                mem[b][w*32 +: 32] = 32'hB000_0000 + 32'(b << 8) + 32'(w);
            end
        end
        mem[0] = {32'h44, 32'h33, 32'h22, 32'h11};
        mem[8][31:0] = 32'hAA;

        RESET = 1'b0;
        PC = 32'h0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busywait", 32'(BUSYWAIT), 32'h1);
        check("rst_mem_read", 32'(MEM_READ), 32'h0);
        check("rst_mem_addr", 32'(MEM_ADDRESS), 32'h0);
        check("rst_instr", INSTRUCTION, 32'h0);

        // Cold miss at L=4
        @(negedge CLK);
        RESET = 1'b1;
        r0 = req_cnt;
        fetch(32'h000, st, ins, ad);
        check("cold_stall", 32'(st), 32'd7);
        check("cold_addr", 32'(ad), 32'h00);
        check("cold_instr", ins, 32'h11);
        check("cold_reqs", 32'(req_cnt - r0), 32'd1);

        // Hits on consecutive cycles
        r0 = req_cnt;
        fetch(32'h004, st, ins, ad);
        check("hit1_stall", 32'(st), 32'd0);
        check("hit1_instr", ins, 32'h22);
        fetch(32'h008, st, ins, ad);
        check("hit2_stall", 32'(st), 32'd0);
        check("hit2_instr", ins, 32'h33);
        fetch(32'h00C, st, ins, ad);
        check("hit3_stall", 32'(st), 32'd0);
        check("hit3_instr", ins, 32'h44);
        check("hit_no_read", 32'(ad), 32'h3f);
        check("hit_reqs", 32'(req_cnt - r0), 32'd0);

        // Conflict on index 0
        fetch(32'h080, st, ins, ad);
        check("conf_stall", 32'(st), 32'd7);
        check("conf_addr", 32'(ad), 32'h08);
        check("conf_instr", ins, 32'hAA);
        fetch(32'h000, st, ins, ad);
        check("evict_stall", 32'(st), 32'd7);
        check("evict_addr", 32'(ad), 32'h00);
        check("evict_instr", ins, 32'h11);

        // Latency sweep on index 7
        mem_lat = 0;
        fetch(32'h0F0, st, ins, ad);
        check("l0_stall", 32'(st), 32'd3);
        check("l0_addr", 32'(ad), 32'h0f);
        check("l0_instr", ins, 32'hB000_0F00);
        mem_lat = 10;
        fetch(32'h1F0, st, ins, ad);
        check("l10_stall", 32'(st), 32'd13);
        check("l10_addr", 32'(ad), 32'h1f);
        fetch(32'h1F4, st, ins, ad);
        check("l10_hit_stall", 32'(st), 32'd0);
        check("l10_hit_instr", ins, 32'hB000_1F01);
        fetch(32'h0F0, st, ins, ad);
        check("l10b_stall", 32'(st), 32'd13);
        check("l10b_instr", ins, 32'hB000_0F00);

        // Aliasing and ignored low bits
        mem_lat = 4;
        fetch(32'h010, st, ins, ad);
        check("alias_fill_stall", 32'(st), 32'd7);
        fetch(32'h411, st, ins, ad);
        check("alias_stall", 32'(st), 32'd0);
        check("alias_instr", ins, 32'hB000_0100);

        // Reset while a refill is outstanding
        PC = 32'h020;
        n = 0;
        while (!MEM_READ && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("mid_req_seen", 32'(MEM_READ), 32'h1);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        check("mid_rst_mem_read", 32'(MEM_READ), 32'h0);
        check("mid_rst_busywait", 32'(BUSYWAIT), 32'h1);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        fetch(32'h000, st, ins, ad);
        check("post_rst_stall", 32'(st), 32'd7);
        check("post_rst_instr", ins, 32'h11);
        fetch(32'h020, st, ins, ad);
        check("no_stale_stall", 32'(st), 32'd7);
        check("no_stale_addr", 32'(ad), 32'h02);
        check("no_stale_instr", ins, 32'hB000_0200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
